// File: rtl/dark_pulse_emulator_pkg.sv
// dark_emu_pkg: state encoding and LFSR constants shared by the dark pulse emulator files
package dark_emu_pkg;
  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_WIDTH-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
  typedef enum logic [1:0] {IDLE, ARMED, PULSE, DEAD} state_t;
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/dark_pulse_emulator_if.sv
// dark_pulse_emulator_if: control/pulse bundle; periodic exists only when DARK_PULSE_PERIODIC_EN is defined
interface dark_pulse_emulator_if #(parameter int CNT_WIDTH = 16);
  logic start, stop;
  logic [15:0] seed, threshold;
  logic [CNT_WIDTH-1:0] npulses;
  logic pulse_out, busy, done;
  logic [CNT_WIDTH-1:0] pulse_count;
`ifdef DARK_PULSE_PERIODIC_EN
  logic periodic;
  modport master(output start, stop, seed, threshold, npulses, periodic, input pulse_out, busy, done, pulse_count);
  modport slave(input start, stop, seed, threshold, npulses, periodic, output pulse_out, busy, done, pulse_count);
`else
  modport master(output start, stop, seed, threshold, npulses, input pulse_out, busy, done, pulse_count);
  modport slave(input start, stop, seed, threshold, npulses, output pulse_out, busy, done, pulse_count);
`endif
endinterface

// File: rtl/dark_pulse_emulator_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with seed load; a zero seed is replaced so the state never locks up
module lfsr16 import dark_emu_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] load_value,
  output logic [LFSR_WIDTH-1:0] state
);
  always_ff @(posedge clk) begin
    if (rst) state <= LFSR_DEFAULT_SEED;
    else if (load) state <= load_value == '0 ? LFSR_DEFAULT_SEED : load_value;
    else if (enable) state <= lfsr_next(state);
  end
endmodule

// File: rtl/dark_pulse_emulator.sv
// dark_pulse_emulator: synthetic MPPC dark-count pulse source with fixed width/dead time and pulse tally.
// Defining DARK_PULSE_PERIODIC_EN adds a periodic input selecting interval-counter firing instead of random.
module dark_pulse_emulator import dark_emu_pkg::*; #(
  parameter int PULSE_WIDTH = 4,
  parameter int DEAD_TIME   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input logic clk,
  input logic rst,
  dark_pulse_emulator_if.slave bus
);
  localparam int TW = $clog2(PULSE_WIDTH > DEAD_TIME ? PULSE_WIDTH : DEAD_TIME) + 1;
  state_t state;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [TW-1:0] timer;
  logic [CNT_WIDTH-1:0] npulses_q;
  logic fire, abort, last;
`ifdef DARK_PULSE_PERIODIC_EN
  logic [15:0] interval;
  always_ff @(posedge clk) begin
    if (rst) interval <= '0;
    else interval <= state == ARMED ? interval + 16'd1 : '0;
  end
  assign fire = bus.periodic ? interval >= bus.threshold : lfsr < bus.threshold;
`else
  assign fire = lfsr < bus.threshold;
`endif
  assign abort = state != IDLE && bus.stop;
  assign last = npulses_q != '0 && bus.pulse_count == npulses_q;
  lfsr16 u_lfsr (
    .clk(clk),
    .rst(rst),
    .enable(state != IDLE),
    .load(state == IDLE && bus.start),
    .load_value(bus.seed),
    .state(lfsr)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      npulses_q       <= '0;
      bus.pulse_out   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pulse_count <= '0;
    end else begin
      bus.done <= 1'b0;
      if (abort) begin
        state         <= IDLE;
        bus.pulse_out <= 1'b0;
        bus.busy      <= 1'b0;
        bus.done      <= 1'b1;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            state           <= ARMED;
            bus.busy        <= 1'b1;
            bus.pulse_count <= '0;
            npulses_q       <= bus.npulses;
          end
          ARMED: if (fire) begin
            state           <= PULSE;
            bus.pulse_out   <= 1'b1;
            timer           <= TW'(PULSE_WIDTH - 1);
            bus.pulse_count <= bus.pulse_count + CNT_WIDTH'(~&bus.pulse_count);
          end
          PULSE: if (timer == '0) begin
            state         <= DEAD;
            bus.pulse_out <= 1'b0;
            timer         <= TW'(DEAD_TIME - 1);
          end else timer <= timer - 1'b1;
          DEAD: if (timer == '0) begin
            state    <= last ? IDLE : ARMED;
            bus.busy <= !last;
            bus.done <= last;
          end else timer <= timer - 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dark_pulse_emulator.sv
// tb_dark_pulse_emulator: directed stimulus checked every cycle against an event-time model plus literal pins
module tb_dark_pulse_emulator;
  localparam int PW = 4, DT = 8, CW = 16;
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, bad = 0;
  bit chk = 0;
  always #5 clk = ~clk;
  dark_pulse_emulator_if #(.CNT_WIDTH(CW)) bus ();
  dark_pulse_emulator #(.PULSE_WIDTH(PW), .DEAD_TIME(DT), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  bit run = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [CW-1:0] m_cnt = '0, target = '0;
  logic m_pulse = 1'b0, m_done = 1'b0;
  int t = 0, cmp_at = 0, hi_end = 0, dead_end = -1;
  // a run is a schedule of compare instants; a fire at edge t owns edges t..t+PW+DT
  always @(posedge clk) begin
    t++;
    m_done = 1'b0;
    if (rst) begin
      run = 0; m_lfsr = 16'hACE1; m_cnt = '0;
    end else if (!run) begin
      if (bus.start) begin
        run = 1; m_lfsr = bus.seed == 16'd0 ? 16'hACE1 : bus.seed; m_cnt = '0;
        target = bus.npulses; cmp_at = t + 1; hi_end = 0; dead_end = -1;
      end
    end else if (bus.stop) begin
      run = 0; m_done = 1'b1;
    end else begin
      if (t == cmp_at) begin
        if (m_lfsr < bus.threshold) begin
          m_cnt = m_cnt + CW'(m_cnt != '1); hi_end = t + PW; dead_end = t + PW + DT; cmp_at = dead_end + 1;
        end else cmp_at = t + 1;
      end else if (t == dead_end && target != '0 && m_cnt == target) begin
        run = 0; m_done = 1'b1;
      end
      m_lfsr = nxt(m_lfsr);
    end
    m_pulse = run && t < hi_end;
  end
  always @(negedge clk) if (chk) begin
    total++;
    if ({bus.pulse_out, bus.busy, bus.done, bus.pulse_count} !== {m_pulse, run, m_done, m_cnt}) begin
      bad++;
      $display("FAIL model t=%0d got pulse=%b busy=%b done=%b count=%0d want pulse=%b busy=%b done=%b count=%0d",
               t, bus.pulse_out, bus.busy, bus.done, bus.pulse_count, m_pulse, run, m_done, m_cnt);
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic quiet_run(input logic [15:0] thr, input int n, input string tag);
    bit seen = 0;
    bus.seed = 16'h1234; bus.threshold = thr; bus.npulses = '0; bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    check({tag, "_start_wins"}, 32'(bus.busy), 1);
    repeat (n) begin
      @(negedge clk);
      seen |= bus.pulse_out;
    end
    check({tag, "_never_fires"}, 32'(seen), 0);
    check({tag, "_busy"}, 32'(bus.busy), 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check({tag, "_stop_done"}, 32'(bus.done), 1);
    check({tag, "_count"}, 32'(bus.pulse_count), 0);
    check({tag, "_idle"}, 32'(bus.busy), 0);
  endtask
  initial begin
    int rises, hi, gap, last, dones, first;
    logic prev;
    bus.start = 1'b0; bus.stop = 1'b0; bus.seed = '0; bus.threshold = '0; bus.npulses = '0;
`ifdef DARK_PULSE_PERIODIC_EN
    bus.periodic = 1'b0;
`endif
    @(negedge clk);
    chk = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_pulse", 32'(bus.pulse_out), 0);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_done", 32'(bus.done), 0);
    check("idle_count", 32'(bus.pulse_count), 0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("idle_stop_no_done", 32'(bus.done), 0);
    // bounded run of 5 pulses at maximum firing rate
    bus.seed = '0; bus.threshold = 16'hFFFF; bus.npulses = CW'(5); bus.start = 1'b1;
    rises = 0; hi = 0; dones = 0; last = -100; gap = 1000; first = -1; prev = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.pulse_out && !prev) begin
        rises++;
        if (first < 0) first = i;
        if (i - last < gap) gap = i - last;
        last = i;
      end
      prev = bus.pulse_out;
      hi += int'(bus.pulse_out);
      dones += int'(bus.done);
    end
    check("first_rise", 32'(first), 2);
    check("rises", 32'(rises), 5);
    check("high_cycles", 32'(hi), 20);
    check("min_gap_ge_13", 32'(gap >= 13), 1);
    check("done_once", 32'(dones), 1);
    check("count_5", 32'(bus.pulse_count), 5);
    check("busy_end", 32'(bus.busy), 0);
    quiet_run(16'h0000, 10000, "thr0");
    quiet_run(16'h0001, 300, "thr1");
    // long random run: the model replays the LFSR decision at every compare
    bus.seed = 16'h1234; bus.threshold = 16'h1000; bus.npulses = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (65536) @(negedge clk);
    check("replay_count", 32'(bus.pulse_count), 32'(m_cnt));
    check("duty_plausible", 32'(bus.pulse_count > 1500 && bus.pulse_count < 3200), 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    // abort on the 2nd high cycle of the 3rd pulse, with a stray start mid-run
    bus.seed = '0; bus.threshold = 16'hFFFF; bus.npulses = '0; bus.start = 1'b1;
    rises = 0; prev = 1'b0;
    for (int i = 1; i <= 100 && rises < 3; i++) begin
      @(negedge clk);
      bus.start = (i == 5);
      if (bus.pulse_out && !prev) rises++;
      prev = bus.pulse_out;
    end
    check("third_rise_seen", 32'(rises), 3);
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("abort_pulse_low", 32'(bus.pulse_out), 0);
    check("abort_done", 32'(bus.done), 1);
    check("abort_count", 32'(bus.pulse_count), 3);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);
    check("count_held", 32'(bus.pulse_count), 3);
    bus.threshold = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_clears", 32'(bus.pulse_count), 0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    // synchronous reset while in dead time
    bus.seed = '0; bus.threshold = 16'hFFFF; bus.start = 1'b1;
    rises = 0; prev = 1'b0;
    for (int i = 1; i <= 100 && rises == 0; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (!bus.pulse_out && prev) rises = 1;
      prev = bus.pulse_out;
    end
    check("dead_reached", 32'(rises), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_pulse", 32'(bus.pulse_out), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_no_done", 32'(bus.done), 0);
    check("rst_count", 32'(bus.pulse_count), 0);
    bus.seed = 16'h0005; bus.threshold = 16'h0006; bus.npulses = CW'(1); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("seed_rise_latency", 32'(bus.pulse_out), 0);
    @(negedge clk);
    check("seed_fires", 32'(bus.pulse_out), 1);
    repeat (20) @(negedge clk);
    check("single_pulse_count", 32'(bus.pulse_count), 1);
    check("single_pulse_idle", 32'(bus.busy), 0);
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dark_pulse_emulator.md
Name: dark_pulse_emulator

Overview:
- Synthetic MPPC dark-count source: drives a discriminator-like pulse stream into the BCD dark-counter path for closed-loop board tests without a sensor.
- Per-cycle Bernoulli firing from a 16-bit LFSR compared against a programmable threshold.
- Fixed pulse width and dead time; optional bounded pulse count; emitted-pulse tally for cross-checking the counter reading.

Parameters:
- PULSE_WIDTH, 4, high time of pulse_out in clk cycles (>=1)
- DEAD_TIME, 8, forced low time after each pulse in clk cycles (>=1)
- CNT_WIDTH, 16, width of npulses and pulse_count

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle start strobe, already debounced/edge-detected upstream
- stop  input  1  single-cycle abort strobe
- seed  input  16  LFSR seed, sampled on accepted start
- threshold  input  16  firing threshold; fire when lfsr < threshold
- npulses  input  CNT_WIDTH  pulses to emit; 0 = free-running until stop
- pulse_out  output  1  emulated discriminator pulse, registered
- busy  output  1  high in ARMED/PULSE/DEAD
- done  output  1  one-cycle strobe on run completion or abort
- pulse_count  output  CNT_WIDTH  pulses emitted since last accepted start, saturating

Behaviour:
- Reset: state IDLE, lfsr=16'hACE1, pulse_out=0, busy=0, done=0, pulse_count=0, timers=0.
- LFSR: Fibonacci, x^16+x^14+x^13+x^11+1, shift left, feedback into bit0. Values 1..65535, never 0.
- LFSR advance: every cycle in ARMED/PULSE/DEAD; holds in IDLE.
- IDLE: start=1 -> lfsr<=seed (seed==0 loads 16'hACE1), pulse_count<=0, go ARMED.
- ARMED: compare current lfsr (pre-advance) with threshold. If lfsr<threshold, go PULSE next cycle.
- Firing range: threshold 0 or 1 never fires; threshold 16'hFFFF fires unless lfsr==16'hFFFF.
- PULSE: pulse_out=1 for exactly PULSE_WIDTH cycles. pulse_out rises the cycle after the firing compare (latency 1).
- pulse_count: increments on PULSE entry and saturates at all-ones.
- DEAD: pulse_out=0 for exactly DEAD_TIME cycles, then:
  - if npulses!=0 and pulse_count==npulses -> IDLE with done=1
  - else -> ARMED
- Minimum pulse period is 1+PULSE_WIDTH+DEAD_TIME cycles.
- stop=1 in ARMED/PULSE/DEAD -> IDLE next cycle: pulse_out=0, done=1, pulse_count held. A truncated pulse still counts.
- stop in IDLE: ignored, no done.
- start outside IDLE: ignored. start and stop in the same cycle in IDLE: start wins.
- threshold changes take effect on the next ARMED compare. npulses is sampled on accepted start.
- done: one cycle wide, coincident with the first IDLE cycle.
- busy: registered, equals (state!=IDLE).
- Synchronous rst mid-run: all outputs return to reset values next cycle, no done strobe.

Optional Feature:
- Macro: DARK_PULSE_PERIODIC_EN.
- When defined:
  - extra input periodic (1 bit).
  - periodic=1: ARMED fires when a 16-bit interval counter, cleared on ARMED entry, reaches threshold. threshold==0 fires on the first ARMED cycle.
  - LFSR still advances.
- When undefined: port absent, random firing only.

Decomposition:
- Shared package dark_emu_pkg: state encoding (IDLE, ARMED, PULSE, DEAD), LFSR_WIDTH=16, LFSR_TAPS=16'hB400, LFSR_DEFAULT_SEED=16'hACE1.
- One sub-module, lfsr16: enable, load, load_value, 16-bit state output, same reset value.
- FSM, timers and tally stay in dark_pulse_emulator.

Test Plan:
- Reset then idle 20 cycles -> pulse_out=0, busy=0, done=0, pulse_count=0.
- seed=0, threshold=16'hFFFF, npulses=5, PULSE_WIDTH=4, DEAD_TIME=8, start -> first pulse_out rise 2 cycles after start. 5 pulses, each 4 cycles high, rising edges >=13 cycles apart. done 1 cycle, pulse_count=5.
- threshold=0, npulses=0, start, run 10000 cycles -> pulse_out never high, busy=1, stop -> done next cycle, pulse_count=0.
- threshold=16'h1000, npulses=0, seed=16'h1234, run 2^16 cycles -> pulse_count matches reference-model LFSR replay exactly, about 6% duty of ARMED cycles.
- stop asserted on 2nd cycle of 3rd pulse -> pulse_out low next cycle, done=1, pulse_count=3, later start clears count to 0.
- rst asserted during DEAD -> next cycle all outputs at reset values, no done. start then restarts from seed.
